// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding, flag bit positions and readout selects for the
// byte-loaded sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FL_Z   = 0;
    localparam int FL_N   = 1;
    localparam int FL_C   = 2;
    localparam int FL_V   = 3;
    localparam int FL_DZ  = 4;
    localparam int FL_ILL = 5;
    localparam int NFLAGS = 6;

    localparam logic [3:0] RD_FLAGS = 4'd15;

    // Division by zero short-circuits, so it never occupies the iterative unit.
    function automatic logic uses_iter(input logic [3:0] op, input logic div_by_zero);
        return (op == OP_MUL) || ((op == OP_DIVU) && !div_by_zero);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative unit: shift-add multiplier and restoring divider sharing one
// hi/lo register pair; exactly WIDTH iterations after start, then a done pulse.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q;
    logic             div_q;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply: hi accumulates, lo holds the multiplier and collects product bits.
    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        fits    = shifted >= {1'b0, opnd_q};
        diff    = shifted[WIDTH-1:0] - opnd_q;

        hi_d   = hi_q;
        lo_d   = lo_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;

        if (start_i) begin
            hi_d  = '0;
            lo_d  = div_i ? a_i : b_i;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (div_q) begin
                hi_d = fits ? diff : shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], fits};
            end else begin
                hi_d = add_sum[WIDTH:1];
                lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            run_q  <= run_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            if (start_i) begin
                opnd_q <= div_i ? b_i : a_i;
                div_q  <= div_i;
            end
        end
    end

    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_seq_core.sv
// Byte-loaded ALU core: operand registers, IDLE/EXEC/DONE sequencer with
// valid/ready command and response, single-cycle ALU and byte readout mux.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_valid,
    input  logic [3:0] ld_sel,
    input  logic [7:0] ld_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    input  logic [3:0] rd_sel,
    output logic [7:0] rd_data,
    output logic       busy,
    output state_t     dbg_state
);

    // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
    // the response (rsp_valid) is held until a rising edge with rsp_ready high.

    localparam int NBYTES = WIDTH / 8;
    localparam int SW     = $clog2(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  res_lo_q, res_hi_q;
    logic [NFLAGS-1:0] flags_q;

    logic              accept;
    logic              res_upd;
    logic              iter_start;
    logic              iter_done;
    logic              exec_done;
    logic [WIDTH-1:0]  it_hi, it_lo;

    logic [SW-1:0]     sh;
    logic [WIDTH:0]    sum_ext, dif_ext, shl_ext;
    logic [WIDTH-1:0]  alu_lo, alu_hi;
    logic              alu_c, alu_v, alu_dz, alu_ill;
    logic [NFLAGS-1:0] alu_flags;

    assign cmd_ready  = (state_q == ST_IDLE) && !ld_valid;
    assign accept     = cmd_valid && cmd_ready;
    assign iter_start = accept && uses_iter(cmd_op, b_q == '0);
    assign exec_done  = uses_iter(op_q, b_q == '0) ? iter_done : 1'b1;

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (iter_start),
        .div_i   (cmd_op == OP_DIVU),
        .a_i     (a_q),
        .b_i     (b_q),
        .done_o  (iter_done),
        .hi_o    (it_hi),
        .lo_o    (it_lo)
    );

    // Single-cycle datapath; also folds in the iterative result and the DIVU-by-zero case.
    always_comb begin
        sh      = b_q[SW-1:0];
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
        dif_ext = {1'b0, a_q} - {1'b0, b_q};
        shl_ext = {1'b0, a_q} << sh;
        alu_lo  = '0;
        alu_hi  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_dz  = 1'b0;
        alu_ill = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_lo = sum_ext[WIDTH-1:0];
                alu_c  = sum_ext[WIDTH];
                alu_v  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_lo = dif_ext[WIDTH-1:0];
                alu_c  = dif_ext[WIDTH];
                alu_v  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_ext[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_lo = a_q & b_q;
            OP_OR:  alu_lo = a_q | b_q;
            OP_XOR: alu_lo = a_q ^ b_q;
            OP_SHL: begin
                alu_lo = shl_ext[WIDTH-1:0];
                alu_c  = shl_ext[WIDTH];
            end
            OP_SHR: alu_lo = a_q >> sh;
            OP_SRA: alu_lo = $unsigned($signed(a_q) >>> sh);
            OP_MUL: begin
                alu_lo = it_lo;
                alu_hi = it_hi;
                alu_c  = (it_hi != '0);
            end
            OP_DIVU: begin
                if (b_q == '0) begin
                    alu_lo = '1;
                    alu_hi = a_q;
                    alu_dz = 1'b1;
                end else begin
                    alu_lo = it_lo;
                    alu_hi = it_hi;
                end
            end
            default: alu_ill = 1'b1;
        endcase
        alu_flags = {alu_ill, alu_dz, alu_v, alu_c, alu_lo[WIDTH-1], alu_lo == '0};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_upd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_valid) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (int'(ld_sel[2:0]) == i) begin
                            if (ld_sel[3]) b_d[i*8 +: 8] = ld_data;
                            else           a_d[i*8 +: 8] = ld_data;
                        end
                    end
                end else if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    state_d = ST_DONE;
                    res_upd = 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            if (accept) op_q <= cmd_op;
            if (res_upd) begin
                res_lo_q <= alu_lo;
                res_hi_q <= alu_hi;
                flags_q  <= alu_flags;
            end
        end
    end

    // Flags select wins even where it overlaps the top RES_HI byte at WIDTH=64.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (int'(rd_sel) == i)          rd_data = res_lo_q[i*8 +: 8];
            if (int'(rd_sel) == i + NBYTES) rd_data = res_hi_q[i*8 +: 8];
        end
        if (rd_sel == RD_FLAGS) rd_data = {2'b00, flags_q};
    end

    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core at WIDTH=32: directed vector table, handshake corner
// sequences and randomized commands against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq_core;
    import alu_seq_pkg::*;

    localparam int W  = 32;
    localparam int NB = W / 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_valid;
    logic [3:0] ld_sel;
    logic [7:0] ld_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rd_sel;
    logic [7:0] rd_data;
    logic       busy;
    state_t     dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] a_m, b_m;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [W-1:0] a, b, lo, hi;
        logic [5:0] fl;
        int         lat;
    } vec_t;

    vec_t vecs[15];

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_sel    (ld_sel),
        .ld_data   (ld_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: results straight from the arithmetic definition of each opcode.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic [5:0] fl, output int lat);
        longint sa, sb, s;
        logic [63:0] wide;
        int sh;
        logic c, v, dz, ill;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % W);
        lo = '0; hi = '0; c = 0; v = 0; dz = 0; ill = 0; lat = 1;
        case (op)
            0: begin
                wide = 64'(a) + 64'(b);
                lo = wide[W-1:0];
                c = wide > 64'(32'hFFFF_FFFF);
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                lo = a - b;
                c = a < b;
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2: lo = a & b;
            3: lo = a | b;
            4: lo = a ^ b;
            5: begin
                lo = a << sh;
                c = (sh != 0) && a[W-sh];
            end
            6: lo = a >> sh;
            7: begin
                s = sa >>> sh;
                lo = s[W-1:0];
            end
            8: begin
                wide = 64'(a) * 64'(b);
                lo = wide[W-1:0];
                hi = wide[2*W-1:W];
                c = hi != 0;
                lat = W + 1;
            end
            9: begin
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                    dz = 1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                    lat = W + 1;
                end
            end
            default: ill = 1;
        endcase
        fl = {ill, dz, v, c, lo[W-1], lo == 0};
    endtask

    task automatic load_word(input logic is_b, input logic [W-1:0] val);
        for (int i = 0; i < NB; i++) begin
            ld_valid = 1'b1;
            ld_sel   = {is_b, 3'(i)};
            ld_data  = val[i*8 +: 8];
            @(negedge clk);
        end
        ld_valid = 1'b0;
        if (is_b) b_m = val;
        else      a_m = val;
    endtask

    task automatic read_result(output logic [W-1:0] lo, output logic [W-1:0] hi, output logic [5:0] fl);
        for (int i = 0; i < NB; i++) begin
            rd_sel = 4'(i);
            #1 lo[i*8 +: 8] = rd_data;
            rd_sel = 4'(i + NB);
            #1 hi[i*8 +: 8] = rd_data;
        end
        rd_sel = RD_FLAGS;
        #1 fl = rd_data[5:0];
    endtask

    // Presents a command at a negedge; lat counts rising edges after the accept edge.
    task automatic issue(input string name, input logic [3:0] op, output int lat, output bit ok);
        cmd_op    = op;
        cmd_valid = 1'b1;
        #1 check({name, "_cmd_ready"}, cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({name, "_busy"}, busy, 1);
        lat = 0;
        ok  = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string name, input logic [3:0] op,
                                 input logic [W-1:0] elo, input logic [W-1:0] ehi,
                                 input logic [5:0] efl, input int elat, input int stall);
        int lat;
        bit ok;
        logic [W-1:0] lo, hi;
        logic [5:0] fl;
        issue(name, op, lat, ok);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no rsp_valid after %0d cycles, required %0d", name, lat, elat);
            return;
        end
        check({name, "_lat"}, lat, elat);
        read_result(lo, hi, fl);
        check({name, "_lo"}, lo, elo);
        check({name, "_hi"}, hi, ehi);
        check({name, "_flags"}, fl, efl);
        for (int k = 0; k < stall; k++) begin
            ld_valid = 1'b1;
            ld_sel   = {1'b0, 3'(k % NB)};
            ld_data  = 8'($urandom);
            rd_sel   = 4'd0;
            #1;
            check({name, "_stall_rsp_valid"}, rsp_valid, 1);
            check({name, "_stall_cmd_ready"}, cmd_ready, 0);
            check({name, "_stall_rd_data"}, rd_data, elo[7:0]);
            @(negedge clk);
        end
        ld_valid  = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 check({name, "_rsp_dropped"}, rsp_valid, 0);
    endtask

    task automatic run_model(input string name, input logic [3:0] op, input int stall);
        logic [W-1:0] lo, hi;
        logic [5:0] fl;
        int lat;
        model(op, a_m, b_m, lo, hi, fl, lat);
        run_and_check(name, op, lo, hi, fl, lat, stall);
    endtask

    task automatic check_idle_cleared(input string name);
        rd_sel = 4'd0;
        #1;
        check({name, "_busy"}, busy, 0);
        check({name, "_rsp_valid"}, rsp_valid, 0);
        check({name, "_cmd_ready"}, cmd_ready, 1);
        check({name, "_state"}, dbg_state, ST_IDLE);
        check({name, "_rd0"}, rd_data, 0);
        rd_sel = RD_FLAGS;
        #1 check({name, "_rdflags"}, rd_data, 0);
    endtask

    initial begin
        vecs[0]  = '{"add_ovf",   OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 32'h0,         6'h0A, 1};
        vecs[1]  = '{"add_carry", OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         6'h05, 1};
        vecs[2]  = '{"sub_borrow",OP_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 32'h0,         6'h06, 1};
        vecs[3]  = '{"sub_ovf",   OP_SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 32'h0,         6'h08, 1};
        vecs[4]  = '{"and",       OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 32'h0,         6'h00, 1};
        vecs[5]  = '{"xor_zero",  OP_XOR,  32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0,         32'h0,         6'h01, 1};
        vecs[6]  = '{"shl_c",     OP_SHL,  32'h8000_0001, 32'h1,         32'h2,         32'h0,         6'h04, 1};
        vecs[7]  = '{"shr_wrap",  OP_SHR,  32'h8000_0000, 32'd36,        32'h0800_0000, 32'h0,         6'h00, 1};
        vecs[8]  = '{"sra",       OP_SRA,  32'h8000_0000, 32'h4,         32'hF800_0000, 32'h0,         6'h02, 1};
        vecs[9]  = '{"mul_max",   OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 6'h04, 33};
        vecs[10] = '{"mul_2p32",  OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1,         6'h05, 33};
        vecs[11] = '{"divu",      OP_DIVU, 32'd100,       32'd7,         32'd14,        32'd2,         6'h00, 33};
        vecs[12] = '{"divu_by1",  OP_DIVU, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 32'h0,         6'h02, 33};
        vecs[13] = '{"divu_zero", OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         6'h12, 1};
        vecs[14] = '{"illegal",   4'd12,   32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         32'h0,         6'h21, 1};

        rst = 1'b1; ld_valid = 1'b0; ld_sel = '0; ld_data = '0;
        cmd_valid = 1'b0; cmd_op = '0; rsp_ready = 1'b0; rd_sel = '0;
        a_m = '0; b_m = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_cleared("reset");

        for (int i = 0; i < 15; i++) begin
            load_word(1'b0, vecs[i].a);
            load_word(1'b1, vecs[i].b);
            run_and_check(vecs[i].name, vecs[i].op, vecs[i].lo, vecs[i].hi, vecs[i].fl, vecs[i].lat, 0);
        end

        rd_sel = 4'd10;
        #1 check("unused_sel", rd_data, 0);

        // Held response: loads are refused and the result stays put.
        load_word(1'b0, 32'h1357_9BDF);
        load_word(1'b1, 32'h0000_00FF);
        run_model("mul_stall", OP_MUL, 10);
        run_model("after_stall_add", OP_ADD, 0);

        // Out-of-range byte indices are dropped.
        load_word(1'b0, 32'h1122_3344);
        load_word(1'b1, 32'h0);
        ld_valid = 1'b1; ld_sel = 4'b0101; ld_data = 8'hAA;
        @(negedge clk);
        ld_sel = 4'b1110; ld_data = 8'hBB;
        @(negedge clk);
        ld_valid = 1'b0;
        run_model("byte_idx_ignored", OP_ADD, 0);

        // Load and command in the same idle cycle: load wins, command follows.
        load_word(1'b0, 32'h0000_0100);
        load_word(1'b1, 32'h0000_0001);
        ld_valid = 1'b1; ld_sel = 4'b0000; ld_data = 8'h55;
        cmd_valid = 1'b1; cmd_op = OP_ADD;
        #1 check("coinc_cmd_ready_low", cmd_ready, 0);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        check("coinc_not_taken", busy, 0);
        check("coinc_cmd_ready_high", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("coinc_taken", busy, 1);
        check("coinc_no_rsp_yet", rsp_valid, 0);
        @(negedge clk);
        check("coinc_rsp", rsp_valid, 1);
        rd_sel = 4'd0;
        #1 check("coinc_byte0", rd_data, 8'h56);
        rd_sel = 4'd1;
        #1 check("coinc_byte1", rd_data, 8'h01);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset in the middle of a multiply aborts with no response.
        load_word(1'b0, 32'hFFFF_1234);
        load_word(1'b1, 32'h0000_00FF);
        cmd_op = OP_MUL; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("midmul_still_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_m = '0; b_m = '0;
        check_idle_cleared("midmul_reset");
        repeat (40) @(negedge clk);
        check("midmul_no_late_rsp", rsp_valid, 0);
        run_model("post_reset_add", OP_ADD, 0);

        for (int n = 0; n < 30; n++) begin
            logic [3:0] op;
            logic [W-1:0] a, b;
            int mode;
            op   = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 3);
            a    = $urandom;
            b    = (mode == 0) ? '0 : (mode == 1) ? W'($urandom_range(1, 40)) : W'($urandom);
            load_word(1'b0, a);
            load_word(1'b1, b);
            run_model($sformatf("rand%0d_op%0d", n, op), op, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
